// File: rtl/enc_pkg.sv
// Shared constants and types for the request encoder / address decoder pair.
package enc_pkg;

  localparam int unsigned N_SLOT = 9;
  localparam int unsigned ADDR_W = 4;

  typedef enum logic {IDLE, GRANT} state_e;

  typedef logic [ADDR_W-1:0] slot_t;

  // Modular add for operands already below n; one subtraction is enough.
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    int unsigned s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0, find the
// lowest set bit, then map the offset back to an absolute slot index.
module rr_pick
  import enc_pkg::*;
#(
  parameter int unsigned N  = N_SLOT,
  parameter int unsigned AW = ADDR_W
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic          found,
  output logic [AW-1:0] idx,
  output logic          multi
);

  localparam int unsigned IW = $clog2(N);

  logic [N-1:0]  rot;
  logic [AW-1:0] off;

  // Rotate so that slot ptr becomes bit 0 of rot.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N; i++) begin
      rot[i] = req[IW'(wrap_add(32'(ptr), 32'(i), N))];
    end
  end

  // Lowest set bit of the rotated vector, translated back to a slot number.
  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        off   = AW'(i);
      end
    end
    idx   = AW'(wrap_add(32'(ptr), 32'(off), N));
    multi = ($countones(req) > 1);
  end

endmodule

// File: rtl/req_encoder.sv
// Round-robin request encoder: grants one of N request lines, presents its
// address with a valid/ack handshake and rotates priority past each grant.
module req_encoder
  import enc_pkg::*;
#(
  parameter int unsigned N  = N_SLOT,
  parameter int unsigned AW = ADDR_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          ack,
  output logic [AW-1:0] add,
  output logic          valid,
  output logic [N-1:0]  grant_oh,
  output logic          multi
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [AW-1:0] add_q, add_d;
  logic          valid_q, valid_d;
  logic [N-1:0]  grant_oh_q, grant_oh_d;
  logic          multi_q, multi_d;

  logic          pick_found;
  logic [AW-1:0] pick_idx;
  logic          pick_multi;

  rr_pick #(
    .N  (N),
    .AW (AW)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .found (pick_found),
    .idx   (pick_idx),
    .multi (pick_multi)
  );

  // Next state: capture a grant from IDLE, hold it frozen until ack.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    add_d      = add_q;
    valid_d    = valid_q;
    grant_oh_d = grant_oh_q;
    multi_d    = multi_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = GRANT;
          add_d      = pick_idx;
          grant_oh_d = N'(1) << pick_idx;
          multi_d    = pick_multi;
          valid_d    = 1'b1;
        end
      end
      GRANT: begin
        // add is left as-is after ack; only valid/grant_oh drop.
        if (ack) begin
          state_d    = IDLE;
          valid_d    = 1'b0;
          grant_oh_d = '0;
          ptr_d      = (add_q == AW'(N - 1)) ? '0 : add_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      add_q      <= '0;
      valid_q    <= 1'b0;
      grant_oh_q <= '0;
      multi_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      add_q      <= add_d;
      valid_q    <= valid_d;
      grant_oh_q <= grant_oh_d;
      multi_q    <= multi_d;
    end
  end

  assign add      = add_q;
  assign valid    = valid_q;
  assign grant_oh = grant_oh_q;
  assign multi    = multi_q;

endmodule
